// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor core.
//
// Fetches one instruction word per instruction from DIN and executes it over a
// handful of FSM states. A memory handshake (MemReady) stretches the fetch,
// load/immediate read and store states. R[NREG-1] doubles as the program counter.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous reset, ACTIVE HIGH (1 = reset)
//   Run        in   start/continue enable, sampled only in StFetch
//   DIN        in   memory read data (instruction or operand)
//   MemReady   in   read data valid / write accepted this cycle
//   AddressOut out  registered memory address
//   DOUT       out  registered store data
//   Write      out  memory write strobe (whole of StWwait)
//   Done       out  high in the final cycle of each instruction
//   State      out  current FSM state encoding (debug)
//   PC         out  current R[NREG-1] (debug)
//
// DATA_W must be at least 4 + 2*REG_AW so the instruction field fits in DIN.
module processador_multiciclo_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              MemReady,
    output logic [DATA_W-1:0] AddressOut,
    output logic [DATA_W-1:0] DOUT,
    output logic              Write,
    output logic              Done,
    output logic [2:0]        State,
    output logic [DATA_W-1:0] PC
);

    localparam int unsigned NREG   = 2 ** REG_AW;
    localparam int unsigned IR_W   = 4 + 2 * REG_AW;
    localparam int unsigned SH_W   = $clog2(DATA_W);
    localparam int unsigned PC_IDX = NREG - 1;

    localparam logic [DATA_W-1:0] ResetPc = DATA_W'(RESET_PC);
    localparam logic [DATA_W-1:0] PcInc   = DATA_W'(1);

    localparam logic [3:0] OpLd   = 4'b0000;
    localparam logic [3:0] OpSt   = 4'b0001;
    localparam logic [3:0] OpMvnz = 4'b0010;
    localparam logic [3:0] OpMv   = 4'b0011;
    localparam logic [3:0] OpMvi  = 4'b0100;
    localparam logic [3:0] OpAdd  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpOr   = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b1001;
    localparam logic [3:0] OpSlr  = 4'b1010;

    typedef enum logic [2:0] {
        StFetch = 3'd0,
        StIwait = 3'd1,
        StEx1   = 3'd2,
        StEx2   = 3'd3,
        StEx3   = 3'd4,
        StRwait = 3'd5,
        StWwait = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   r_q [NREG];
    logic [DATA_W-1:0]   r_d [NREG];
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   g_q, g_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;

    logic [3:0]          op;
    logic [REG_AW-1:0]   rx;
    logic [REG_AW-1:0]   ry;
    logic [DATA_W-1:0]   b_val;
    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   alu;

    assign op    = ir_q[IR_W-1 -: 4];
    assign rx    = ir_q[2*REG_AW-1 -: REG_AW];
    assign ry    = ir_q[REG_AW-1:0];
    assign b_val = r_q[ry];
    assign shamt = b_val[SH_W-1:0];

    always_comb begin
        alu = '0;
        case (op)
            OpAdd:   alu = a_q + b_val;
            OpSub:   alu = a_q - b_val;
            OpOr:    alu = a_q | b_val;
            OpSlt:   alu = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_val))};
            OpSll:   alu = a_q << shamt;
            OpSlr:   alu = a_q >> shamt;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        Write   = 1'b0;
        Done    = 1'b0;

        case (state_q)
            StFetch: begin
                if (Run) begin
                    addr_d         = r_q[PC_IDX];
                    r_d[PC_IDX]    = r_q[PC_IDX] + PcInc;
                    state_d        = StIwait;
                end
            end
            StIwait: begin
                if (MemReady) begin
                    ir_d    = DIN[IR_W-1:0];
                    state_d = StEx1;
                end
            end
            StEx1: begin
                case (op)
                    OpLd: begin
                        addr_d  = r_q[ry];
                        state_d = StRwait;
                    end
                    OpSt: begin
                        addr_d  = r_q[ry];
                        dout_d  = r_q[rx];
                        state_d = StWwait;
                    end
                    OpMv: begin
                        r_d[rx] = r_q[ry];
                        Done    = 1'b1;
                        state_d = StFetch;
                    end
                    OpMvnz: begin
                        if (g_q != '0) begin
                            r_d[rx] = r_q[ry];
                        end
                        Done    = 1'b1;
                        state_d = StFetch;
                    end
                    OpMvi: begin
                        // Immediate lives in the word after the instruction.
                        addr_d      = r_q[PC_IDX];
                        r_d[PC_IDX] = r_q[PC_IDX] + PcInc;
                        state_d     = StRwait;
                    end
                    OpAdd, OpSub, OpOr, OpSlt, OpSll, OpSlr: begin
                        a_d     = r_q[rx];
                        state_d = StEx2;
                    end
                    default: begin
                        // Undefined opcodes retire as a NOP.
                        Done    = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StEx2: begin
                g_d     = alu;
                state_d = StEx3;
            end
            StEx3: begin
                r_d[rx] = g_q;
                Done    = 1'b1;
                state_d = StFetch;
            end
            StRwait: begin
                if (MemReady) begin
                    r_d[rx] = DIN;
                    Done    = 1'b1;
                    state_d = StFetch;
                end
            end
            StWwait: begin
                Write = 1'b1;
                if (MemReady) begin
                    Done    = 1'b1;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_q[i] <= (i == PC_IDX) ? ResetPc : '0;
            end
            state_q <= StFetch;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            r_q     <= r_d;
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    assign AddressOut = addr_q;
    assign DOUT       = dout_q;
    assign State      = state_q;
    assign PC         = r_q[PC_IDX];

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Bench for processador_multiciclo_param: a 16-bit/8-register instance runs a
// table of instructions whose results are exposed through stores, checked by a
// write scoreboard; a 32-bit/16-register instance checks RESET_PC and a PC jump.
module tb_processador_multiciclo_param;

    localparam logic [3:0] OpLd   = 4'b0000;
    localparam logic [3:0] OpSt   = 4'b0001;
    localparam logic [3:0] OpMvnz = 4'b0010;
    localparam logic [3:0] OpMv   = 4'b0011;
    localparam logic [3:0] OpMvi  = 4'b0100;
    localparam logic [3:0] OpAdd  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpOr   = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b1001;
    localparam logic [3:0] OpSlr  = 4'b1010;
    localparam logic [3:0] OpNop  = 4'b1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        run1, mr1, write1, done1;
    logic [15:0] din1, addr1, dout1, pc1;
    logic [2:0]  state1;
    logic        run2, mr2, write2, done2;
    logic [31:0] din2, addr2, dout2, pc2;
    logic [2:0]  state2;

    logic [15:0] mem1 [0:255];
    logic [31:0] mem2 [0:255];

    assign din1 = mem1[addr1[7:0]];
    assign din2 = mem2[addr2[7:0]];

    always #5 clk = ~clk;

    processador_multiciclo_param #(.DATA_W(16), .REG_AW(3), .RESET_PC(0)) dut1 (
        .Clock(clk), .Resetn(rst), .Run(run1), .DIN(din1), .MemReady(mr1),
        .AddressOut(addr1), .DOUT(dout1), .Write(write1), .Done(done1),
        .State(state1), .PC(pc1)
    );

    processador_multiciclo_param #(.DATA_W(32), .REG_AW(4), .RESET_PC(16)) dut2 (
        .Clock(clk), .Resetn(rst), .Run(run2), .DIN(din2), .MemReady(mr2),
        .AddressOut(addr2), .DOUT(dout2), .Write(write2), .Done(done2),
        .State(state2), .PC(pc2)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  op;
        int          rx;
        int          ry;
        logic [15:0] imm;
        int          stalls;
        int          cyc;
        logic [15:0] val;  // expected store data for st rows
    } row_t;

    wr_t  sb_q[$];
    row_t rows[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc1(input logic [3:0] op, input int rx, input int ry);
        return {6'b101101, op, 3'(rx), 3'(ry)};
    endfunction

    function automatic logic [31:0] enc2(input logic [3:0] op, input int rx, input int ry);
        return {20'hDEAD0, op, 4'(rx), 4'(ry)};
    endfunction

    // Runs one instruction from StFetch (entered at a negedge) until Done, inserting
    // `stalls` MemReady=0 cycles in the data wait states; returns at a negedge in StFetch.
    task automatic exec_one(input bit sel, input int stalls, output int cyc, output int wr_cyc,
                            output logic [31:0] fetch_addr, output logic [31:0] done_addr);
        int          left;
        logic [2:0]  st;
        logic        dn, w, rdy;
        wr_t         exp_wr;
        logic [31:0] a_now, d_now;
        left = stalls;
        cyc = 1;
        wr_cyc = 0;
        fetch_addr = '0;
        done_addr = '0;
        if (sel) run2 = 1'b1; else run1 = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            st = sel ? state2 : state1;
            rdy = !(((st == 3'd5) || (st == 3'd6)) && (left > 0));
            if (!rdy) left--;
            if (sel) mr2 = rdy; else mr1 = rdy;
            #1;
            a_now = sel ? addr2 : {16'h0, addr1};
            d_now = sel ? dout2 : {16'h0, dout1};
            dn = sel ? done2 : done1;
            w  = sel ? write2 : write1;
            if (cyc == 2) fetch_addr = a_now;
            if (w) wr_cyc++;
            if (w && rdy) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got addr %0h data %0h, expected none",
                             a_now, d_now);
                end else begin
                    exp_wr = sb_q.pop_front();
                    check("sb_addr", a_now, exp_wr.addr);
                    check("sb_data", d_now, exp_wr.data);
                end
            end
            if (dn) begin
                done_addr = a_now;
                break;
            end
            if (cyc > 64) begin
                check("exec_timeout", 32'(cyc), 32'd0);
                break;
            end
        end
        run1 = 1'b0;
        run2 = 1'b0;
        mr1 = 1'b1;
        mr2 = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int          cyc, wr;
        logic [31:0] fa, da;
        logic [15:0] pc_m;
        int          k, seen;
        row_t        r;

        for (int i = 0; i < 256; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
        mem1[8'h40] = 16'h5A5A;

        rows.push_back('{OpMvi,  5, 0, 16'h0040, 0, 4, 16'h0000});
        rows.push_back('{OpSt,   1, 5, 16'h0000, 0, 4, 16'h00AB});
        rows.push_back('{OpMvi,  2, 0, 16'h7FFF, 0, 4, 16'h0000});
        rows.push_back('{OpMvi,  3, 0, 16'h0001, 0, 4, 16'h0000});
        rows.push_back('{OpMvnz, 1, 2, 16'h0000, 0, 3, 16'h0000});  // G=0: no copy
        rows.push_back('{OpSt,   1, 5, 16'h0000, 0, 4, 16'h00AB});
        rows.push_back('{OpAdd,  2, 3, 16'h0000, 0, 5, 16'h0000});
        rows.push_back('{OpSt,   2, 5, 16'h0000, 0, 4, 16'h8000});
        rows.push_back('{OpSlt,  2, 3, 16'h0000, 0, 5, 16'h0000});
        rows.push_back('{OpSt,   2, 5, 16'h0000, 0, 4, 16'h0001});
        rows.push_back('{OpSub,  0, 3, 16'h0000, 0, 5, 16'h0000});
        rows.push_back('{OpSt,   0, 5, 16'h0000, 0, 4, 16'hFFFF});
        rows.push_back('{OpMvi,  4, 0, 16'h1234, 0, 4, 16'h0000});
        rows.push_back('{OpSt,   4, 5, 16'h0000, 3, 7, 16'h1234});
        rows.push_back('{OpMvi,  6, 0, 16'h0003, 0, 4, 16'h0000});
        rows.push_back('{OpMvi,  0, 0, 16'h0002, 0, 4, 16'h0000});
        rows.push_back('{OpAdd,  0, 6, 16'h0000, 0, 5, 16'h0000});  // G=5
        rows.push_back('{OpMvnz, 1, 2, 16'h0000, 0, 3, 16'h0000});  // copies R2=1
        rows.push_back('{OpSt,   1, 5, 16'h0000, 0, 4, 16'h0001});
        rows.push_back('{OpSt,   0, 5, 16'h0000, 0, 4, 16'h0005});
        rows.push_back('{OpMvi,  2, 0, 16'h0013, 0, 4, 16'h0000});
        rows.push_back('{OpSll,  6, 2, 16'h0000, 0, 5, 16'h0000});
        rows.push_back('{OpSt,   6, 5, 16'h0000, 0, 4, 16'h0018});
        rows.push_back('{OpMvi,  4, 0, 16'h8000, 0, 4, 16'h0000});
        rows.push_back('{OpMvi,  3, 0, 16'h002F, 0, 4, 16'h0000});
        rows.push_back('{OpSlr,  4, 3, 16'h0000, 0, 5, 16'h0000});
        rows.push_back('{OpSt,   4, 5, 16'h0000, 0, 4, 16'h0001});
        rows.push_back('{OpNop,  4, 3, 16'h0000, 0, 3, 16'h0000});
        rows.push_back('{OpSt,   4, 5, 16'h0000, 0, 4, 16'h0001});
        rows.push_back('{OpMv,   0, 6, 16'h0000, 0, 3, 16'h0000});
        rows.push_back('{OpSt,   0, 5, 16'h0000, 0, 4, 16'h0018});
        rows.push_back('{OpLd,   1, 5, 16'h0000, 2, 6, 16'h0000});
        rows.push_back('{OpSt,   1, 5, 16'h0000, 0, 4, 16'h5A5A});
        rows.push_back('{OpMvi,  3, 0, 16'h00C3, 1, 5, 16'h0000});
        rows.push_back('{OpOr,   3, 1, 16'h0000, 0, 5, 16'h0000});
        rows.push_back('{OpSt,   3, 5, 16'h0000, 0, 4, 16'h5ADB});
        rows.push_back('{OpSlt,  3, 1, 16'h0000, 0, 5, 16'h0000});  // 0x5ADB < 0x5A5A false
        rows.push_back('{OpSt,   3, 5, 16'h0000, 0, 4, 16'h0000});

        rst = 1'b1;
        run1 = 1'b0;
        run2 = 1'b0;
        mr1 = 1'b1;
        mr2 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state1), 32'd0);
        check("rst_write", 32'(write1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_addr", 32'(addr1), 32'd0);
        check("rst_dout", 32'(dout1), 32'd0);
        check("rst_pc", 32'(pc1), 32'd0);

        // mvi R1, 0x00AB from address 0
        mem1[0] = enc1(OpMvi, 1, 0);
        mem1[1] = 16'h00AB;
        exec_one(1'b0, 0, cyc, wr, fa, da);
        check("t1_cycles", 32'(cyc), 32'd4);
        check("t1_fetch_addr", fa, 32'd0);
        check("t1_imm_addr", da, 32'd1);
        check("t1_pc", 32'(pc1), 32'd2);
        check("t1_write_cycles", 32'(wr), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("t1_idle_state", 32'(state1), 32'd0);
        check("t1_idle_done", 32'(done1), 32'd0);

        pc_m = 16'd2;
        for (int i = 0; i < rows.size(); i++) begin
            r = rows[i];
            mem1[pc_m[7:0]] = enc1(r.op, r.rx, r.ry);
            pc_m = pc_m + 16'd1;
            if (r.op == OpMvi) begin
                mem1[pc_m[7:0]] = r.imm;
                pc_m = pc_m + 16'd1;
            end
            if (r.op == OpSt) sb_q.push_back('{32'h0000_0040, {16'h0, r.val}});
            exec_one(1'b0, r.stalls, cyc, wr, fa, da);
            check($sformatf("row%0d_cycles", i), 32'(cyc), 32'(r.cyc));
            check($sformatf("row%0d_pc", i), 32'(pc1), {16'h0, pc_m});
            check($sformatf("row%0d_write_cycles", i), 32'(wr),
                  (r.op == OpSt) ? 32'(r.stalls + 1) : 32'd0);
        end

        // Reset while a store is stalled in the write-wait state.
        mem1[pc_m[7:0]] = enc1(OpSt, 4, 5);
        run1 = 1'b1;
        k = 0;
        seen = 0;
        while ((seen < 3) && (k < 40)) begin
            @(negedge clk);
            k++;
            run1 = 1'b0;
            mr1 = (state1 != 3'd6);
            #1;
            if (state1 == 3'd6) seen++;
        end
        check("abort_write_before", 32'(write1), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_write", 32'(write1), 32'd0);
        check("abort_state", 32'(state1), 32'd0);
        check("abort_done", 32'(done1), 32'd0);
        check("abort_addr", 32'(addr1), 32'd0);
        check("abort_dout", 32'(dout1), 32'd0);
        check("abort_pc", 32'(pc1), 32'd0);
        mr1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Registers cleared: R4 and R1 store as 0 to address R5=0; R7 stores its live PC.
        mem1[0] = enc1(OpSt, 4, 5);
        mem1[1] = enc1(OpSt, 1, 5);
        mem1[2] = enc1(OpSt, 7, 6);
        sb_q.push_back('{32'h0, 32'h0});
        sb_q.push_back('{32'h0, 32'h0});
        sb_q.push_back('{32'h0, 32'h3});
        for (int i = 0; i < 3; i++) begin
            exec_one(1'b0, 0, cyc, wr, fa, da);
            check($sformatf("post_rst%0d_cycles", i), 32'(cyc), 32'd4);
        end
        check("post_rst_pc", 32'(pc1), 32'd3);

        // Wide instance: RESET_PC, then mv R15,R3 jumps to 0x30.
        check("w_reset_pc", pc2, 32'h10);
        mem2[16] = enc2(OpMvi, 3, 0);
        mem2[17] = 32'h0000_0030;
        mem2[18] = enc2(OpMv, 15, 3);
        mem2[8'h30] = enc2(4'b1101, 2, 1);
        exec_one(1'b1, 0, cyc, wr, fa, da);
        check("w_mvi_cycles", 32'(cyc), 32'd4);
        check("w_mvi_pc", pc2, 32'h12);
        exec_one(1'b1, 0, cyc, wr, fa, da);
        check("w_mv_cycles", 32'(cyc), 32'd3);
        check("w_jump_pc", pc2, 32'h30);
        exec_one(1'b1, 0, cyc, wr, fa, da);
        check("w_jump_fetch_addr", fa, 32'h30);
        check("w_nop_cycles", 32'(cyc), 32'd3);
        check("w_nop_pc", pc2, 32'h31);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/processador_multiciclo_param.md
Name: processador_multiciclo_param

Overview:
- Parametrised multicycle processor core, the next generation of the team's 16-bit multicycle processor.
- Generalises data width and register-file depth and replaces the counter-driven time steps with an explicit state machine.
- Adds a memory wait-state handshake (MemReady), instruction-granular Run gating and defined behaviour for undefined opcodes.
- Sits between the instruction/data memory (DIN/AddressOut/DOUT/Write) and the system top level.

Parameters:
- DATA_W, 16, datapath, register and address width. Constraint: DATA_W >= 4+2*REG_AW.
- REG_AW, 3, register index width. NREG = 2^REG_AW registers; R[NREG-1] is the PC.
- RESET_PC, 0, value loaded into the PC on reset.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  asynchronous, active-high reset (despite the name, 1 = reset).
- Run  in  1  start/continue enable, sampled only in S_FETCH.
- DIN  in  DATA_W  memory read data (instruction or operand).
- MemReady  in  1  memory handshake: read data valid / write accepted this cycle.
- AddressOut  out  DATA_W  registered memory address.
- DOUT  out  DATA_W  registered store data.
- Write  out  1  memory write strobe.
- Done  out  1  high during the final cycle of each instruction.
- State  out  3  current FSM state encoding, for debug.
- PC  out  DATA_W  current R[NREG-1], for debug.

Behaviour:
- Reset (asynchronous, effective immediately):
  - All R[i] = 0 except PC = RESET_PC.
  - IR, A, G, AddressOut, DOUT = 0.
  - State = S_FETCH.
  - Write = 0 and Done = 0 (both are combinational from the state).
  - Reset mid-instruction aborts it; no partial write completes.
- Instruction word: IR = DIN[4+2*REG_AW-1:0]. Opcode I = IR[top 4 bits], X = next REG_AW bits, Y = low REG_AW bits. DIN bits above this field are ignored.
- Opcode map: ld=0000, st=0001, mvnz=0010, mv=0011, mvi=0100, add=0101, sub=0110, or=0111, slt=1000, sll=1001, slr=1010.
- States and encodings:
  - S_FETCH (0): if Run=1, AddressOut <= PC and PC <= PC+1 (mod 2^DATA_W), go to S_IWAIT. If Run=0, hold with nothing changing.
  - S_IWAIT (1): wait for MemReady=1, then IR <= DIN field and go to S_EX1. If MemReady=0, stay.
  - S_EX1 (2), by opcode:
    - ld: AddressOut <= R[Y], go to S_RWAIT.
    - st: AddressOut <= R[Y] and DOUT <= R[X], go to S_WWAIT.
    - mv: R[X] <= R[Y]; Done=1; go to S_FETCH.
    - mvnz: R[X] <= R[Y] only if G != 0; Done=1; go to S_FETCH.
    - mvi: AddressOut <= PC and PC <= PC+1, go to S_RWAIT.
    - ALU ops (add..slr): A <= R[X], go to S_EX2.
    - opcodes 1011..1111: NOP; Done=1; go to S_FETCH.
  - S_EX2 (3): G <= ALU(A, R[Y]), go to S_EX3.
  - S_EX3 (4): R[X] <= G; Done=1; go to S_FETCH.
  - S_RWAIT (5): on MemReady=1, R[X] <= DIN, Done=1, go to S_FETCH. Otherwise stay.
  - S_WWAIT (6): Write=1 for the whole state. On MemReady=1, Done=1 and go to S_FETCH. Otherwise stay.
- Latency with MemReady tied high:
  - mv, mvnz and NOP: 3 cycles.
  - ld, st and mvi: 4 cycles.
  - ALU ops: 5 cycles.
  - Each MemReady=0 cycle adds one cycle.
- ALU rules (results mod 2^DATA_W):
  - add, sub: wrap on overflow/underflow.
  - or: bitwise OR.
  - slt: 1 if A < B as signed two's complement, else 0.
  - sll/slr: logical shift of A by B[$clog2(DATA_W)-1:0]; slr zero-fills.
- G changes only in S_EX2; mvnz tests the last ALU result (G=0 after reset).
- Writing R[NREG-1] via mv/mvnz/ld/mvi/ALU acts as a jump; the next fetch uses the written value. The PC increment and a PC write never share a cycle.
- Run=0 mid-instruction has no effect; the instruction completes and the core stops in S_FETCH.
- Writes to R[X] occur only in the cycle Done=1.

Test Plan:
- Reset, RESET_PC=0, Run=1, MemReady=1, DIN=mvi R1 then 0x00AB -> AddressOut=0 then 1; R1=0x00AB; PC=2; Done high exactly once, 4 cycles after fetch start.
- R2=0x7FFF, R3=0x0001, add R2,R3 -> R2=0x8000 in 5 cycles; then slt R2,R3 -> R2=1 (signed 0x8000 < 1); sub R0(=0),R3 -> R0=0xFFFF.
- st R4,R5 with R4=0x1234, R5=0x0040, MemReady low for 3 cycles in S_WWAIT -> AddressOut=0x0040, DOUT=0x1234, Write high 4 cycles, Done on the 4th, PC unchanged by the store.
- mvnz R1,R2 with G=0, then after an add producing G=5 -> first leaves R1 unchanged; second copies R2 into R1.
- sll with R[Y]=0x0013, DATA_W=16 -> shift amount 3 (low 4 bits); slr of 0x8000 by 15 -> 0x0001. Opcode 1100 -> NOP, Done after 3 cycles.
- Resetn pulsed in S_WWAIT with Write=1 -> Write=0 immediately, State=0, all registers 0. Second build with DATA_W=32, REG_AW=4 -> mv R15,R3 jumps the PC.
